// File: rtl/multicycle_controller_pkg.sv
// riscv_ctrl_pkg: shared encodings for the multicycle RV32I control unit.
//   - main FSM state codes (4-bit, legacy-compatible localparams)
//   - supported opcodes, ALU-op classes, and the datapath select encodings
//   - branch_funct3_ok(): which branch funct3 values the build supports
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (adds bne, funct3 = 001).
package riscv_ctrl_pkg;

  typedef logic [3:0] state_t;

  localparam state_t StFetch    = 4'd0;
  localparam state_t StDecode   = 4'd1;
  localparam state_t StMemAdr   = 4'd2;
  localparam state_t StMemRead  = 4'd3;
  localparam state_t StMemWb    = 4'd4;
  localparam state_t StMemWrite = 4'd5;
  localparam state_t StExecuteR = 4'd6;
  localparam state_t StExecuteI = 4'd7;
  localparam state_t StAluWb    = 4'd8;
  localparam state_t StBranch   = 4'd9;
  localparam state_t StJal      = 4'd10;

  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [1:0] AluOpAdd   = 2'b00;
  localparam logic [1:0] AluOpSub   = 2'b01;
  localparam logic [1:0] AluOpFunct = 2'b10;

  localparam logic [2:0] AluCtlAdd = 3'b000;
  localparam logic [2:0] AluCtlSub = 3'b001;
  localparam logic [2:0] AluCtlAnd = 3'b010;
  localparam logic [2:0] AluCtlOr  = 3'b011;
  localparam logic [2:0] AluCtlSlt = 3'b101;

  localparam logic [1:0] ImmI = 2'b00;
  localparam logic [1:0] ImmS = 2'b01;
  localparam logic [1:0] ImmB = 2'b10;
  localparam logic [1:0] ImmJ = 2'b11;

  localparam logic [1:0] ResAluOut    = 2'b00;
  localparam logic [1:0] ResData      = 2'b01;
  localparam logic [1:0] ResAluResult = 2'b10;

  localparam logic [1:0] SrcAPc    = 2'b00;
  localparam logic [1:0] SrcAOldPc = 2'b01;
  localparam logic [1:0] SrcARegA  = 2'b10;

  localparam logic [1:0] SrcBRegB = 2'b00;
  localparam logic [1:0] SrcBImm  = 2'b01;
  localparam logic [1:0] SrcBFour = 2'b10;

  function automatic logic branch_funct3_ok(input logic [2:0] funct3);
`ifdef MULTICYCLE_CTRL_BNE_EN
    return (funct3 == 3'b000) || (funct3 == 3'b001);
`else
    return (funct3 == 3'b000);
`endif
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: bundle between the control unit and the datapath.
//   Datapath -> control: op, funct3, funct7b5, zero
//   Control -> datapath: pc_write, adr_src, mem_write, ir_write, reg_write,
//                        result_src, alu_src_a, alu_src_b, imm_src, alu_control,
//                        illegal_op
// master = control unit side, slave = datapath side.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal_op;

  modport master (
    input  op, funct3, funct7b5, zero,
    output pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_op
  );

  modport slave (
    output op, funct3, funct7b5, zero,
    input  pc_write, adr_src, mem_write, ir_write, reg_write, result_src,
           alu_src_a, alu_src_b, imm_src, alu_control, illegal_op
  );
endinterface

// File: rtl/multicycle_controller_alu_decoder.sv
// alu_decoder: combinational ALU control decode.
//   aluop[1:0]  - class from the main FSM (add / sub / by funct3)
//   funct3[2:0] - instr[14:12]
//   op5         - instr[5], distinguishes R-type from I-type
//   funct7b5    - instr[30]
//   alu_control - ALU operation select
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alu_control
);

  always_comb begin
    alu_control = AluCtlAdd;
    case (aluop)
      AluOpAdd: alu_control = AluCtlAdd;
      AluOpSub: alu_control = AluCtlSub;
      AluOpFunct: begin
        case (funct3)
          // addi has op5 = 0, so funct7b5 (part of its immediate) must not select sub.
          3'b000:  alu_control = (op5 & funct7b5) ? AluCtlSub : AluCtlAdd;
          3'b010:  alu_control = AluCtlSlt;
          3'b110:  alu_control = AluCtlOr;
          3'b111:  alu_control = AluCtlAnd;
          default: alu_control = AluCtlAdd;
        endcase
      end
      default: alu_control = AluCtlAdd;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: control unit for the multicycle RV32I core.
// Moore main FSM (Fetch/Decode/Execute/Writeback), immediate-format decode,
// branch resolution and an alu_decoder instance.
// Ports:
//   clk   - core clock, rising edge
//   reset - synchronous, active-high; forces FETCH and masks all write enables
//   ctrl  - multicycle_controller_if.master (instruction fields and zero in,
//           datapath controls out)
// Optional feature macro: MULTICYCLE_CTRL_BNE_EN (branch funct3 = 001 is bne).
module multicycle_controller
  import riscv_ctrl_pkg::*;
(
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master ctrl
);

  state_t state_q, state_d;
  state_t state_cur;

  logic       adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, aluop;
  logic       pc_update, branch, illegal, take;

  always_ff @(posedge clk) begin
    if (reset) state_q <= StFetch;
    else       state_q <= state_d;
  end

  // While reset is high the outputs show FETCH regardless of the stored state.
  assign state_cur = reset ? StFetch : state_q;

  always_comb begin
    state_d    = StFetch;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    result_src = ResAluOut;
    alu_src_a  = SrcAPc;
    alu_src_b  = SrcBRegB;
    aluop      = AluOpAdd;
    pc_update  = 1'b0;
    branch     = 1'b0;
    illegal    = 1'b0;
    case (state_cur)
      StFetch: begin
        ir_write   = 1'b1;
        alu_src_b  = SrcBFour;
        result_src = ResAluResult;
        pc_update  = 1'b1;
        state_d    = StDecode;
      end
      StDecode: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBImm;
        case (ctrl.op)
          OP_LW, OP_SW: state_d = StMemAdr;
          OP_RTYPE:     state_d = StExecuteR;
          OP_ITYPE:     state_d = StExecuteI;
          OP_JAL:       state_d = StJal;
          OP_BRANCH: begin
            if (branch_funct3_ok(ctrl.funct3)) state_d = StBranch;
            else                               illegal = 1'b1;
          end
          default:      illegal = 1'b1;
        endcase
      end
      StMemAdr: begin
        alu_src_a = SrcARegA;
        alu_src_b = SrcBImm;
        state_d   = (ctrl.op == OP_SW) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src = 1'b1;
        state_d = StMemWb;
      end
      StMemWb: begin
        result_src = ResData;
        reg_write  = 1'b1;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
      end
      StExecuteR: begin
        alu_src_a = SrcARegA;
        aluop     = AluOpFunct;
        state_d   = StAluWb;
      end
      StExecuteI: begin
        alu_src_a = SrcARegA;
        alu_src_b = SrcBImm;
        aluop     = AluOpFunct;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write = 1'b1;
      end
      StBranch: begin
        alu_src_a = SrcARegA;
        aluop     = AluOpSub;
        branch    = 1'b1;
      end
      StJal: begin
        alu_src_a = SrcAOldPc;
        alu_src_b = SrcBFour;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      default: state_d = StFetch;
    endcase
  end

  // Branch condition; the ALU computes rs1 - rs2, so zero means equal.
  always_comb begin
    take = 1'b0;
    case (ctrl.funct3)
      3'b000:  take = ctrl.zero;
`ifdef MULTICYCLE_CTRL_BNE_EN
      3'b001:  take = ~ctrl.zero;
`endif
      default: take = 1'b0;
    endcase
  end

  always_comb begin
    case (ctrl.op)
      OP_SW:     ctrl.imm_src = ImmS;
      OP_BRANCH: ctrl.imm_src = ImmB;
      OP_JAL:    ctrl.imm_src = ImmJ;
      default:   ctrl.imm_src = ImmI;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop       (aluop),
    .funct3      (ctrl.funct3),
    .op5         (ctrl.op[5]),
    .funct7b5    (ctrl.funct7b5),
    .alu_control (ctrl.alu_control)
  );

  assign ctrl.pc_write   = (pc_update | (branch & take)) & ~reset;
  assign ctrl.ir_write   = ir_write & ~reset;
  assign ctrl.mem_write  = mem_write & ~reset;
  assign ctrl.reg_write  = reg_write & ~reset;
  assign ctrl.illegal_op = illegal & ~reset;
  assign ctrl.adr_src    = adr_src;
  assign ctrl.result_src = result_src;
  assign ctrl.alu_src_a  = alu_src_a;
  assign ctrl.alu_src_b  = alu_src_b;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. A reference model lists, per
// instruction class, the sequence of spec-defined steps and the control word
// each step must show; every cycle's outputs are compared against it.
module tb_multicycle_controller;

`ifdef MULTICYCLE_CTRL_BNE_EN
  localparam bit BneEn = 1'b1;
`else
  localparam bit BneEn = 1'b0;
`endif

  localparam logic [6:0] Lw = 7'b0000011, Sw = 7'b0100011, Rt = 7'b0110011;
  localparam logic [6:0] It = 7'b0010011, Br = 7'b1100011, Jal = 7'b1101111;

  localparam int StepFetch = 0, StepDecode = 1, StepMemAdr = 2, StepMemRead = 3;
  localparam int StepMemWb = 4, StepMemWrite = 5, StepExecR = 6, StepExecI = 7;
  localparam int StepAluWb = 8, StepBranch = 9, StepJal = 10;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal_op;
  } ctl_t;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;
  ctl_t act, exp;

  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .ctrl  (bus)
  );

  always #5 clk = ~clk;

  assign act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.reg_write,
                bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                bus.alu_control, bus.illegal_op};

  function automatic bit legal(input logic [6:0] op, input logic [2:0] f3);
    case (op)
      Lw, Sw, Rt, It, Jal: return 1'b1;
      Br:                  return (f3 == 3'd0) || (BneEn && f3 == 3'd1);
      default:             return 1'b0;
    endcase
  endfunction

  // Step i of an instruction, or -1 once the instruction has ended.
  function automatic int step_at(input logic [6:0] op, input logic [2:0] f3, input int i);
    int s[5];
    s = '{StepFetch, StepDecode, -1, -1, -1};
    if (legal(op, f3)) begin
      case (op)
        Lw:      s = '{StepFetch, StepDecode, StepMemAdr, StepMemRead, StepMemWb};
        Sw:      s = '{StepFetch, StepDecode, StepMemAdr, StepMemWrite, -1};
        Rt:      s = '{StepFetch, StepDecode, StepExecR, StepAluWb, -1};
        It:      s = '{StepFetch, StepDecode, StepExecI, StepAluWb, -1};
        Br:      s = '{StepFetch, StepDecode, StepBranch, -1, -1};
        default: s = '{StepFetch, StepDecode, StepJal, StepAluWb, -1};
      endcase
    end
    return s[i];
  endfunction

  function automatic ctl_t model(input int step, input logic [6:0] op, input logic [2:0] f3,
                                 input logic f7, input logic z);
    ctl_t c;
    int   alu_class;  // 0 add, 1 sub, 2 by funct3
    c = '0;
    alu_class = 0;
    c.imm_src = (op == Sw) ? 2'b01 : (op == Br) ? 2'b10 : (op == Jal) ? 2'b11 : 2'b00;
    case (step)
      StepFetch: begin
        c.ir_write = 1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_write = 1;
      end
      StepDecode: begin
        c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.illegal_op = !legal(op, f3);
      end
      StepMemAdr:   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
      StepMemRead:  c.adr_src = 1;
      StepMemWb:    begin c.result_src = 2'b01; c.reg_write = 1; end
      StepMemWrite: begin c.adr_src = 1; c.mem_write = 1; end
      StepExecR:    begin c.alu_src_a = 2'b10; alu_class = 2; end
      StepExecI:    begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; alu_class = 2; end
      StepAluWb:    c.reg_write = 1;
      StepBranch: begin
        c.alu_src_a = 2'b10; alu_class = 1;
        c.pc_write = (f3 == 3'd0) ? z : (BneEn && f3 == 3'd1) ? !z : 1'b0;
      end
      StepJal:      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1; end
      default:      c = '0;
    endcase
    if (alu_class == 1) c.alu_control = 3'b001;
    else if (alu_class == 2) begin
      case (f3)
        3'b000:  c.alu_control = (op[5] && f7) ? 3'b001 : 3'b000;
        3'b010:  c.alu_control = 3'b101;
        3'b110:  c.alu_control = 3'b011;
        3'b111:  c.alu_control = 3'b010;
        default: c.alu_control = 3'b000;
      endcase
    end
    return c;
  endfunction

  // Outputs expected while reset is high: FETCH values with every write masked.
  function automatic ctl_t reset_view(input logic [6:0] op);
    ctl_t c;
    c = model(StepFetch, op, 3'd0, 1'b0, 1'b0);
    c.pc_write = 0; c.ir_write = 0; c.mem_write = 0; c.reg_write = 0; c.illegal_op = 0;
    return c;
  endfunction

  task automatic test_reset();
    logic z;
    reset = 1'b1;
    bus.op = It; bus.funct3 = 3'b110; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp = reset_view(It);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL reset cycle %0d: got %h want %h", i, act, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    for (int i = 0; i < 5 && step_at(It, 3'b110, i) >= 0; i++) begin
      z = 1'($urandom_range(0, 1));
      bus.zero = z;
      @(negedge clk);
      exp = model(step_at(It, 3'b110, i), It, 3'b110, 1'b0, z);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL after_reset ori cycle %0d: got %h want %h", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_add();
    logic z;
    for (int k = 0; k < 2; k++) begin
      bus.op = Rt; bus.funct3 = 3'b000; bus.funct7b5 = k[0];
      for (int i = 0; i < 5 && step_at(Rt, 3'b000, i) >= 0; i++) begin
        z = 1'($urandom_range(0, 1));
        bus.zero = z;
        @(negedge clk);
        exp = model(step_at(Rt, 3'b000, i), Rt, 3'b000, k[0], z);
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL add_sub f7b5=%0d cycle %0d: got %h want %h", k, i, act, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_lw_sw();
    logic [6:0] op;
    logic [2:0] f3;
    logic       z;
    for (int k = 0; k < 2; k++) begin
      op = (k == 0) ? Lw : Sw;
      f3 = 3'b010;
      bus.op = op; bus.funct3 = f3; bus.funct7b5 = 1'($urandom_range(0, 1));
      for (int i = 0; i < 5 && step_at(op, f3, i) >= 0; i++) begin
        z = 1'($urandom_range(0, 1));
        bus.zero = z;
        @(negedge clk);
        exp = model(step_at(op, f3, i), op, f3, bus.funct7b5, z);
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL %s cycle %0d: got %h want %h", (k == 0) ? "lw" : "sw", i, act, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_beq();
    for (int k = 0; k < 2; k++) begin
      bus.op = Br; bus.funct3 = 3'b000; bus.funct7b5 = 1'b0; bus.zero = k[0];
      for (int i = 0; i < 5 && step_at(Br, 3'b000, i) >= 0; i++) begin
        @(negedge clk);
        exp = model(step_at(Br, 3'b000, i), Br, 3'b000, 1'b0, k[0]);
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL beq zero=%0d cycle %0d: got %h want %h", k, i, act, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_jal();
    logic z;
    bus.op = Jal; bus.funct3 = 3'($urandom); bus.funct7b5 = 1'($urandom_range(0, 1));
    for (int i = 0; i < 5 && step_at(Jal, bus.funct3, i) >= 0; i++) begin
      z = 1'($urandom_range(0, 1));
      bus.zero = z;
      @(negedge clk);
      exp = model(step_at(Jal, bus.funct3, i), Jal, bus.funct3, bus.funct7b5, z);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL jal cycle %0d: got %h want %h", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [6:0] ops[3];
    logic [2:0] f3s[3];
    ops = '{7'b1111111, Br, Br};
    f3s = '{3'b000, 3'b010, 3'b001};  // bne is illegal unless the feature is built in
    for (int k = 0; k < 3; k++) begin
      bus.op = ops[k]; bus.funct3 = f3s[k]; bus.funct7b5 = 1'b0;
      for (int i = 0; i < 5 && step_at(ops[k], f3s[k], i) >= 0; i++) begin
        bus.zero = 1'($urandom_range(0, 1));
        @(negedge clk);
        exp = model(step_at(ops[k], f3s[k], i), ops[k], f3s[k], 1'b0, bus.zero);
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL illegal op=%b f3=%b cycle %0d: got %h want %h",
                   ops[k], f3s[k], i, act, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset_mid_op();
    bus.op = Lw; bus.funct3 = 3'b010; bus.funct7b5 = 1'b0; bus.zero = 1'b0;
    // FETCH, DECODE, MEMADR run normally; reset lands in MEMREAD.
    for (int i = 0; i < 4; i++) begin
      if (i == 3) reset = 1'b1;
      @(negedge clk);
      exp = (i == 3) ? reset_view(Lw) : model(step_at(Lw, 3'b010, i), Lw, 3'b010, 1'b0, 1'b0);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL reset_mid lw cycle %0d: got %h want %h", i, act, exp);
      end
      @(posedge clk); #1;
    end
    reset = 1'b0;
    // Restart from FETCH: the abandoned lw must not write in what was MEMWB.
    for (int i = 0; i < 5 && step_at(Lw, 3'b010, i) >= 0; i++) begin
      @(negedge clk);
      exp = model(step_at(Lw, 3'b010, i), Lw, 3'b010, 1'b0, 1'b0);
      vectors++;
      if (act !== exp) begin
        miscompares++;
        $display("FAIL restart lw cycle %0d: got %h want %h", i, act, exp);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_random();
    logic [6:0] op;
    logic [2:0] f3;
    logic       f7, z;
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 6))
        0:       op = Lw;
        1:       op = Sw;
        2:       op = Rt;
        3:       op = It;
        4:       op = Br;
        5:       op = Jal;
        default: op = 7'($urandom);
      endcase
      f3 = (op == Br) ? 3'($urandom_range(0, 2)) : 3'($urandom);
      f7 = 1'($urandom_range(0, 1));
      bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7;
      for (int i = 0; i < 5 && step_at(op, f3, i) >= 0; i++) begin
        z = 1'($urandom_range(0, 1));
        bus.zero = z;
        @(negedge clk);
        exp = model(step_at(op, f3, i), op, f3, f7, z);
        vectors++;
        if (act !== exp) begin
          miscompares++;
          $display("FAIL random #%0d op=%b f3=%b f7=%0d cycle %0d: got %h want %h",
                   n, op, f3, f7, i, act, exp);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_sw();
    test_beq();
    test_jal();
    test_illegal();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle RV32I core. It drives the register file's write enable and the datapath's multiplexer, ALU and memory controls, and it consumes the decoded instruction fields and the ALU zero flag. A Moore main FSM steps each instruction through Fetch/Decode/Execute/Writeback. A combinational ALU decoder and branch logic complete the block.

## Interface
Parameters: none.

Ports (the reset is synchronous and active-high):
- clk  in  1  core clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high reset
- op  in  7  instr[6:0], taken from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU result equals zero
- pc_write  out  1  PC register load enable
- adr_src  out  1  memory address select: 0 = PC, 1 = result
- mem_write  out  1  data memory write enable
- ir_write  out  1  instruction register load enable
- reg_write  out  1  register file write enable (RegWrite)
- result_src  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- alu_src_a  out  2  00 = PC, 01 = OldPC, 10 = RegA
- alu_src_b  out  2  00 = RegB, 01 = ImmExt, 10 = constant 4
- imm_src  out  2  00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- illegal_op  out  1  one-cycle pulse in Decode when the opcode is unsupported

## Operation
- **States:** FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH, JAL.
- **FETCH:** adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, aluop=00, result_src=10, pc_update=1. Next state is DECODE.
- **DECODE:** alu_src_a=01, alu_src_b=01, aluop=00 (computes the branch/jump target). Next state by op:
  - 0000011 (lw) or 0100011 (sw) → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - any other opcode → FETCH, with illegal_op=1 and no writes
- **MEMADR:** alu_src_a=10, alu_src_b=01, aluop=00. Next is MEMREAD for lw, MEMWRITE for sw.
- **MEMREAD:** result_src=00, adr_src=1. Next is MEMWB.
- **MEMWB:** result_src=01, reg_write=1. Next is FETCH.
- **MEMWRITE:** result_src=00, adr_src=1, mem_write=1. Next is FETCH.
- **EXECUTER:** alu_src_a=10, alu_src_b=00, aluop=10. Next is ALUWB.
- **EXECUTEI:** alu_src_a=10, alu_src_b=01, aluop=10. Next is ALUWB.
- **ALUWB:** result_src=00, reg_write=1. Next is FETCH.
- **BRANCH:** alu_src_a=10, alu_src_b=00, aluop=01, result_src=00, branch=1. Next is FETCH.
- **JAL:** alu_src_a=01, alu_src_b=10, aluop=00, result_src=00, pc_update=1. Next is ALUWB.
- **Defaults:** every output not listed for a state is 0.
- **imm_src:** decoded from op in every state. lw/I-type → 00, sw → 01, branch → 10, jal → 11, otherwise 00.
- **pc_write:** pc_update | (branch & take), where take = zero for funct3=000.
- **ALU decoder:**
  - aluop 00 → add
  - aluop 01 → sub
  - aluop 10 → by funct3: 000 → sub if op[5] & funct7b5, else add; 010 → slt; 110 → or; 111 → and; any other funct3 → add
- **Branch funct3:** without the macro, only funct3=000 is supported. A branch opcode with any other funct3 pulses illegal_op in DECODE and returns to FETCH.

## Timing
- **Reset:** reset high at a rising edge forces state to FETCH. While reset is high, pc_write, ir_write, mem_write, reg_write and illegal_op are forced to 0; the other outputs show FETCH values.
- **Reset mid-instruction:** the instruction is abandoned and no write occurs on or after the reset edge. The first fetch happens in the first cycle with reset low.
- **Cycles per instruction:** lw 5, sw 4, R-type 4, I-type 4, branch 3, jal 4, illegal 2.
- **Output timing:** state-derived outputs are registered-state Moore outputs. pc_write and alu_control additionally depend combinationally on zero, funct3, funct7b5 and op in the same cycle.
- **Inputs:** op, funct3 and funct7b5 must be stable from DECODE until the return to FETCH. The controller does not latch them.

## Configuration
- Macro: MULTICYCLE_CTRL_BNE_EN.
- **Defined:** in BRANCH, funct3=001 gives take = ~zero (bne). funct3=000 keeps take = zero. Other funct3 values are illegal in DECODE.
- **Undefined:** behaviour is exactly as in Operation; funct3=001 is illegal.

## Structure
- Package `riscv_ctrl_pkg` holds:
  - the state enum
  - opcode localparams (OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL)
  - alu_control, imm_src, result_src and src-select encodings
- Sub-module `alu_decoder`, purely combinational: aluop, funct3, op[5], funct7b5 → alu_control.
- The FSM, imm decode and branch logic stay in the top module.

## Test plan
- **Reset:** reset held for 2 cycles, then released. During reset all write enables are 0; the next cycle is FETCH with ir_write=1, pc_write=1, alu_src_b=10.
- **add:** op=0110011, funct3=000, funct7b5=0. State sequence is FETCH, DECODE, EXECUTER (alu_control=000), ALUWB (reg_write=1, result_src=00), FETCH: 4 cycles. Repeating with funct7b5=1 gives alu_control=001.
- **lw then sw:**
  - lw (op=0000011) has reg_write=1 only in cycle 5, with result_src=01.
  - sw (op=0100011) has mem_write=1 only in cycle 4, with adr_src=1 and imm_src=01.
- **beq:** op=1100011, funct3=000.
  - zero=1 in BRANCH → pc_write=1.
  - zero=0 → pc_write=0.
  - Both cases: alu_control=001.
- **jal:** op=1101111. Sequence is FETCH, DECODE, JAL (pc_write=1, alu_src_a=01, alu_src_b=10), ALUWB (reg_write=1): 4 cycles, imm_src=11.
- **Illegal and reset mid-op:**
  - op=1111111: illegal_op pulses in DECODE, next state FETCH, no writes.
  - Reset asserted in MEMREAD of an lw: no reg_write occurs and the FSM restarts at FETCH.
